// File: rtl/eq_band_mixer_if.sv
// -----------------------------------------------------------------------------
// eq_band_mixer_if
//
// Purpose : Bundles the band-sample input, the gain switches and the mixed
//           output of the equalizer band mixer into one connection.
//
// Signals :
//   new_data      1          one-cycle strobe, band_in valid
//   band_in       5*DATA_W   signed band samples, band k at [DATA_W*k +: DATA_W]
//   gain_sel      10         2-bit gain code per band, band k at [2k +: 2]
//   sample_out    DATA_W     signed mixed, saturated sample
//   sample_valid  1          one-cycle pulse when sample_out updates
//   clip          1          saturation indicator
//   overrun       1          one-cycle pulse when new_data arrives while busy
//
// Modports:
//   master : the side that supplies band samples and consumes the mix
//   slave  : the mixer itself
//
// DATA_W must match the DATA_W of the eq_band_mixer instance it connects to.
// -----------------------------------------------------------------------------
interface eq_band_mixer_if #(
   parameter int DATA_W  = 16,
   parameter int N_BANDS = 5
);

   logic                          new_data;
   logic [N_BANDS*DATA_W-1:0]     band_in;
   logic [2*N_BANDS-1:0]          gain_sel;
   logic signed [DATA_W-1:0]      sample_out;
   logic                          sample_valid;
   logic                          clip;
   logic                          overrun;

   modport master (
      output new_data,
      output band_in,
      output gain_sel,
      input  sample_out,
      input  sample_valid,
      input  clip,
      input  overrun
   );

   modport slave (
      input  new_data,
      input  band_in,
      input  gain_sel,
      output sample_out,
      output sample_valid,
      output clip,
      output overrun
   );

endinterface

// File: rtl/eq_band_mixer.sv
// -----------------------------------------------------------------------------
// eq_band_mixer
//
// Purpose : Mixes the five FIR band outputs of the 5-band equalizer into one
//           sample for the I2S transmitter. Each band is scaled by a gain that
//           ramps toward its switch-selected target (no zipper noise on switch
//           changes), products are accumulated with one time-shared
//           multiplier, and the sum is saturated to DATA_W bits.
//
// Ports   :
//   clk    in  sample-domain clock
//   rst_n  in  asynchronous active-low reset
//   bus    eq_band_mixer_if.slave (new_data, band_in, gain_sel in;
//          sample_out, sample_valid, clip, overrun out)
//
// Timing  : new_data sampled at edge N -> sample_valid high in the cycle that
//           starts at edge N+7. The block is busy for the 7 edges N+1..N+7;
//           a strobe seen at any of them raises overrun and is ignored.
//
// Gain codes: 00 -> mute, 01 -> x0.5, 10 -> x1, 11 -> x2 (unity = 2^GAIN_FRAC).
//
// Optional feature, macro EQ_MIX_CLIP_HOLD_EN:
//   defined   : clip is a hold indicator; set by any saturating sample and
//               cleared only after 4096 consecutive clean samples.
//   undefined : clip is a single-cycle flag aligned with sample_valid.
// -----------------------------------------------------------------------------
module eq_band_mixer #(
   parameter int DATA_W    = 16,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 5,
   parameter int RAMP_STEP = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   eq_band_mixer_if.slave bus
);

   localparam int N_BANDS = 5;
   localparam int PROD_W  = DATA_W + GAIN_W + 1;     // signed sample x signed({0,gain})
   localparam int ACC_W   = PROD_W + 3;              // headroom for five products
   localparam int T_W     = ACC_W - GAIN_FRAC;       // accumulator after de-scaling
   localparam int K_W     = 3;

   localparam logic [K_W-1:0]           K_LAST     = K_W'(N_BANDS - 1);
   localparam logic [GAIN_W-1:0]        GAIN_UNITY = GAIN_W'(2 ** GAIN_FRAC);
   localparam logic [GAIN_W-1:0]        GAIN_HALF  = GAIN_W'(2 ** (GAIN_FRAC - 1));
   localparam logic [GAIN_W-1:0]        GAIN_DBL   = GAIN_W'(2 ** (GAIN_FRAC + 1));
   localparam logic [GAIN_W-1:0]        STEP_G     = GAIN_W'(RAMP_STEP);
   localparam logic signed [T_W-1:0]    T_MAX      = T_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [T_W-1:0]    T_MIN      = T_W'(-(2 ** (DATA_W - 1)));
   localparam logic signed [DATA_W-1:0] DATA_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] DATA_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_SAT,
      S_OUT
   } state_t;

   function automatic logic [GAIN_W-1:0] code_to_gain(input logic [1:0] code);
      case (code)
         2'b00:   return '0;
         2'b01:   return GAIN_HALF;
         2'b10:   return GAIN_UNITY;
         default: return GAIN_DBL;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t                    r_state;
   state_t                    w_state_nxt;

   logic signed [DATA_W-1:0]  r_band   [N_BANDS];
   logic [GAIN_W-1:0]         r_target [N_BANDS];
   logic [GAIN_W-1:0]         r_gain   [N_BANDS];
   logic signed [ACC_W-1:0]   r_acc;
   logic [K_W-1:0]            r_k;
   logic signed [DATA_W-1:0]  r_result;
   logic                      r_sat;

   logic signed [DATA_W-1:0]  r_sample_out;
   logic                      r_valid;
   logic                      r_overrun;
   logic                      r_clip;

   // FSM decoded controls
   logic                      w_capture;
   logic                      w_mac_en;
   logic                      w_sat_en;
   logic                      w_out_en;
   logic                      w_busy_strobe;

   // Datapath combinational nets
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [T_W-1:0]     w_t;
   logic                      w_sat_any;
   logic signed [DATA_W-1:0]  w_sat_val;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: a default assignment ahead of the case keeps every path assigned,
      // so no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.new_data) w_state_nxt = S_MAC;
         S_MAC:   if (r_k == K_LAST) w_state_nxt = S_SAT;
         S_SAT:   w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_capture     = 1'b0;
      w_mac_en      = 1'b0;
      w_sat_en      = 1'b0;
      w_out_en      = 1'b0;
      w_busy_strobe = 1'b0;
      case (r_state)
         S_IDLE:  w_capture     = bus.new_data;
         S_MAC:   w_mac_en      = 1'b1;
         S_SAT:   w_sat_en      = 1'b1;
         S_OUT:   w_out_en      = 1'b1;
         default: w_capture     = 1'b0;
      endcase
      if (r_state != S_IDLE) w_busy_strobe = bus.new_data;
   end

   // ---------------------------------------------------------------------------
   // Time-shared multiplier and saturation
   // ---------------------------------------------------------------------------
   // The zero-extended gain makes the multiply signed x non-negative, so the
   // product sign follows the band sample.
   assign w_prod     = $signed(r_band[r_k]) * $signed({1'b0, r_gain[r_k]});
   assign w_prod_ext = ACC_W'(w_prod);

   // Arithmetic shift floors toward minus infinity (e.g. -3.5 -> -4).
   assign w_t = T_W'(r_acc >>> GAIN_FRAC);

   always_comb begin
      w_sat_any = 1'b0;
      w_sat_val = w_t[DATA_W-1:0];
      if (w_t > T_MAX) begin
         w_sat_any = 1'b1;
         w_sat_val = DATA_MAX;
      end else if (w_t < T_MIN) begin
         w_sat_any = 1'b1;
         w_sat_val = DATA_MIN;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers: capture, MAC, saturate, gain ramp
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the small band/gain arrays are reset on purpose: the gains
         // must start at zero so the output fades in, and clearing the rest
         // costs nothing and keeps simulation free of X.
         for (int i = 0; i < N_BANDS; i++) begin
            r_band[i]   <= '0;
            r_target[i] <= '0;
            r_gain[i]   <= '0;
         end
         r_acc    <= '0;
         r_k      <= '0;
         r_result <= '0;
         r_sat    <= 1'b0;
      end else begin
         if (w_capture) begin
            for (int i = 0; i < N_BANDS; i++) begin
               r_band[i]   <= bus.band_in[i*DATA_W +: DATA_W];
               r_target[i] <= code_to_gain(bus.gain_sel[2*i +: 2]);
            end
            r_acc <= '0;
            r_k   <= '0;
         end

         if (w_mac_en) begin
            r_acc <= r_acc + w_prod_ext;
            r_k   <= r_k + K_W'(1);
         end

         if (w_sat_en) begin
            r_result <= w_sat_val;
            r_sat    <= w_sat_any;
         end

         // Ramp after the sample is computed, so a new target is heard from
         // the next sample on. Snap to the target when within one step.
         if (w_out_en) begin
            for (int i = 0; i < N_BANDS; i++) begin
               if (r_gain[i] < r_target[i]) begin
                  if ((r_target[i] - r_gain[i]) < STEP_G) r_gain[i] <= r_target[i];
                  else                                    r_gain[i] <= r_gain[i] + STEP_G;
               end else if (r_gain[i] > r_target[i]) begin
                  if ((r_gain[i] - r_target[i]) < STEP_G) r_gain[i] <= r_target[i];
                  else                                    r_gain[i] <= r_gain[i] - STEP_G;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_out <= '0;
         r_valid      <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_valid   <= w_out_en;
         r_overrun <= w_busy_strobe;
         if (w_out_en) r_sample_out <= r_result;
      end
   end

`ifdef EQ_MIX_CLIP_HOLD_EN
   // Hold indicator: counts clean samples since the last clip; the 4096th
   // consecutive clean sample (counter at all-ones) releases it.
   logic [11:0] r_clean_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clip      <= 1'b0;
         r_clean_cnt <= '0;
      end else if (w_out_en) begin
         if (r_sat) begin
            r_clip      <= 1'b1;
            r_clean_cnt <= '0;
         end else if (r_clip) begin
            if (&r_clean_cnt) begin
               r_clip      <= 1'b0;
               r_clean_cnt <= '0;
            end else begin
               r_clean_cnt <= r_clean_cnt + 12'd1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clip <= 1'b0;
      else        r_clip <= w_out_en & r_sat;
   end
`endif

   assign bus.sample_out   = r_sample_out;
   assign bus.sample_valid = r_valid;
   assign bus.overrun      = r_overrun;
   assign bus.clip         = r_clip;

endmodule

// File: tb/tb_eq_band_mixer.sv
// -----------------------------------------------------------------------------
// tb_eq_band_mixer
//
// Scoreboard bench for eq_band_mixer. The stimulus process computes each
// expected sample from a behavioural model (per-band gains stepped toward the
// code targets, floor division by 32, clamp to 16 bits) and queues it; a
// monitor compares every sample_valid against the queue head.
// -----------------------------------------------------------------------------
module tb_eq_band_mixer;

   localparam int DATA_W = 16;

   typedef struct {
      int d;
      bit c;
   } exp_t;

   logic clk;
   logic rst_n;

   eq_band_mixer_if #(.DATA_W(DATA_W)) bus ();

   eq_band_mixer #(
      .DATA_W    (DATA_W),
      .GAIN_W    (8),
      .GAIN_FRAC (5),
      .RAMP_STEP (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks  = 0;
   int   errors  = 0;
   exp_t sb_q[$];
   int   ovr_seen = 0;
   int   ovr_exp  = 0;

   // Behavioural model state
   int   cur_band [5];
   int   m_gain   [5];
   int   gain_tab [4] = '{0, 16, 32, 64};
   bit   m_hold;
   int   m_clean;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 5; k++) m_gain[k] = 0;
      m_hold  = 1'b0;
      m_clean = 0;
      sb_q.delete();
   endtask

   // Expected output for the current bands with the current gains, then step
   // every gain toward the target selected by this sample's codes.
   task automatic model_push(input logic [9:0] sel);
      longint sum;
      longint t;
      bit     sat;
      exp_t   e;
      int     tgt;
      sum = 0;
      for (int k = 0; k < 5; k++) sum += longint'(cur_band[k]) * longint'(m_gain[k]);
      if (sum >= 0) t = sum / 32;
      else          t = -((-sum + 31) / 32);
      sat = 1'b0;
      if (t > 32767)       begin t = 32767;  sat = 1'b1; end
      else if (t < -32768) begin t = -32768; sat = 1'b1; end
      e.d = int'(t);
`ifdef EQ_MIX_CLIP_HOLD_EN
      if (sat) begin
         m_hold  = 1'b1;
         m_clean = 0;
      end else if (m_hold) begin
         m_clean++;
         if (m_clean == 4096) begin
            m_hold  = 1'b0;
            m_clean = 0;
         end
      end
      e.c = m_hold;
`else
      e.c = sat;
`endif
      sb_q.push_back(e);
      for (int k = 0; k < 5; k++) begin
         tgt = gain_tab[(sel >> (2*k)) & 10'd3];
         if (tgt > m_gain[k])      m_gain[k] = (m_gain[k] + 4 > tgt) ? tgt : m_gain[k] + 4;
         else if (tgt < m_gain[k]) m_gain[k] = (m_gain[k] - 4 < tgt) ? tgt : m_gain[k] - 4;
      end
   endtask

   task automatic drive_bands();
      for (int k = 0; k < 5; k++) bus.band_in[k*16 +: 16] = 16'(cur_band[k]);
   endtask

   // Strobe one sample and return after gap cycles; with gap = 8 it returns at
   // the negedge where that sample's sample_valid is high.
   task automatic send(input logic [9:0] sel, input int gap);
      @(negedge clk);
      drive_bands();
      bus.gain_sel = sel;
      bus.new_data = 1'b1;
      model_push(sel);
      @(negedge clk);
      bus.new_data = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic set_bands(input int b0, input int b1, input int b2,
                            input int b3, input int b4);
      cur_band[0] = b0; cur_band[1] = b1; cur_band[2] = b2;
      cur_band[3] = b3; cur_band[4] = b4;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: every output sample is checked against the queue head
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.overrun) ovr_seen++;
         if (bus.sample_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got sample_out=%0d, expected no sample (t=%0t)",
                        bus.sample_out, $time);
            end else begin
               e = sb_q.pop_front();
               check("sample_out", bus.sample_out, e.d);
               check("clip", {31'd0, bus.clip}, {31'd0, e.c});
            end
         end
`ifndef EQ_MIX_CLIP_HOLD_EN
         else check("clip_idle", {31'd0, bus.clip}, 32'sd0);
`endif
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got no completion, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int ramp_tab [10] = '{0, 125, 250, 375, 500, 625, 750, 875, 1000, 1000};
      int cnt;

      rst_n        = 1'b0;
      bus.new_data = 1'b0;
      bus.band_in  = '0;
      bus.gain_sel = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_sample_out", bus.sample_out, 32'sd0);
      check("rst_valid",   {31'd0, bus.sample_valid}, 32'sd0);
      check("rst_clip",    {31'd0, bus.clip},         32'sd0);
      check("rst_overrun", {31'd0, bus.overrun},      32'sd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp from reset: band0 = 1000 at x1, one strobe every 64 cycles
      set_bands(1000, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         send(10'b00_00_00_00_10, 64);
         check("ramp_step", bus.sample_out, ramp_tab[i]);
      end

      // Mix at unity, then band1 ramps to x2
      set_bands(100, 200, 300, 400, 500);
      for (int i = 0; i < 9; i++) send(10'b10_10_10_10_10, 8);
      check("mix_unity", bus.sample_out, 32'sd1500);
      check("mix_unity_clip", {31'd0, bus.clip}, 32'sd0);
      for (int i = 0; i < 9; i++) send(10'b10_10_10_11_10, 8);
      check("mix_band1_x2", bus.sample_out, 32'sd1700);

      // Positive and negative saturation at x2
      set_bands(30000, 30000, 30000, 30000, 30000);
      for (int i = 0; i < 9; i++) send(10'h3FF, 8);
      check("sat_pos", bus.sample_out, 32'sd32767);
      check("sat_pos_clip", {31'd0, bus.clip}, 32'sd1);
      set_bands(-30000, -30000, -30000, -30000, -30000);
      send(10'h3FF, 8);
      check("sat_neg", bus.sample_out, -32'sd32768);
      check("sat_neg_clip", {31'd0, bus.clip}, 32'sd1);

      // Half gain on a small negative sample: floor(-3.5) = -4
      set_bands(0, 0, -7, 0, 0);
      for (int i = 0; i < 13; i++) send(10'b00_00_01_00_00, 8);
      check("half_floor", bus.sample_out, -32'sd4);

      // Overrun during MAC: second strobe at edge N+3 is ignored
      set_bands(1000, -2000, 3000, 500, -700);
      @(negedge clk);
      drive_bands();
      bus.gain_sel = 10'b10_10_10_10_10;
      bus.new_data = 1'b1;
      model_push(10'b10_10_10_10_10);
      @(negedge clk);                       // after edge N
      bus.new_data = 1'b0;
      @(negedge clk);                       // after edge N+1
      @(negedge clk);                       // after edge N+2
      check("ovr_quiet", {31'd0, bus.overrun}, 32'sd0);
      bus.band_in  = {5{16'h1234}};
      bus.gain_sel = 10'h3FF;
      bus.new_data = 1'b1;
      @(negedge clk);                       // after edge N+3
      check("ovr_mac_pulse", {31'd0, bus.overrun}, 32'sd1);
      ovr_exp++;
      bus.new_data = 1'b0;
      cnt = 3;
      while (!bus.sample_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("latency", cnt, 32'sd7);

      // Overrun in OUT (edge N+7), then a normal strobe
      set_bands(-1500, 2500, 0, 4000, -300);
      @(negedge clk);
      drive_bands();
      bus.gain_sel = 10'b01_11_10_01_11;
      bus.new_data = 1'b1;
      model_push(10'b01_11_10_01_11);
      @(negedge clk);                       // after edge N
      bus.new_data = 1'b0;
      repeat (6) @(negedge clk);            // after edge N+6
      bus.band_in  = {5{16'h7FFF}};
      bus.new_data = 1'b1;
      @(negedge clk);                       // after edge N+7
      check("ovr_out_pulse", {31'd0, bus.overrun}, 32'sd1);
      ovr_exp++;
      bus.new_data = 1'b0;
      set_bands(800, 800, 800, 800, 800);
      send(10'b10_10_10_10_10, 8);

      // Random bands, codes and strobe spacing
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 5; k++) cur_band[k] = int'($urandom_range(0, 65535)) - 32768;
         send(10'($urandom_range(0, 1023)), int'($urandom_range(8, 20)));
      end
      repeat (12) @(negedge clk);

      // Reset in the middle of MAC: no partial sample, gains restart at 0
      set_bands(10000, 10000, 10000, 10000, 10000);
      send(10'h3FF, 8);
      @(negedge clk);
      drive_bands();
      bus.new_data = 1'b1;
      @(negedge clk);
      bus.new_data = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_sample_out", bus.sample_out, 32'sd0);
      check("midrst_valid",   {31'd0, bus.sample_valid}, 32'sd0);
      check("midrst_clip",    {31'd0, bus.clip},         32'sd0);
      check("midrst_overrun", {31'd0, bus.overrun},      32'sd0);
      model_reset();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      set_bands(1000, 0, 0, 0, 0);
      send(10'b00_00_00_00_10, 8);
      check("post_rst_fade_in", bus.sample_out, 32'sd0);
      check("post_rst_valid", {31'd0, bus.sample_valid}, 32'sd1);

`ifdef EQ_MIX_CLIP_HOLD_EN
      // Hold indicator: clip, 4095 clean samples keep it, the 4096th clears it
      set_bands(30000, 30000, 30000, 30000, 30000);
      for (int i = 0; i < 16; i++) send(10'h3FF, 8);
      set_bands(0, 0, 0, 0, 0);
      for (int i = 0; i < 4095; i++) send(10'h3FF, 8);
      check("hold_after_4095", {31'd0, bus.clip}, 32'sd1);
      send(10'h3FF, 8);
      check("hold_after_4096", {31'd0, bus.clip}, 32'sd0);
`endif

      cnt = 0;
      while (sb_q.size() != 0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("scoreboard_drained", sb_q.size(), 32'sd0);
      check("overrun_count", ovr_seen, ovr_exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
